packet_tx_merge: RTL



---
 rtl/packet_tx_merge.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/packet_tx_merge.sv
// packet_tx_merge: packet-granular merge of the RoCEv2 TX stream and the
// non-RoCEv2 TX stream into a single AXI-stream towards the MAC.
// A source that wins arbitration keeps the grant until its tlast beat.
// Ties in IDLE go to the source that did not win last. One output register
// stage; per-source packet counters are provided for debug.
module packet_tx_merge #(
   parameter int AXIS_DATA_WIDTH = 512,
   parameter int AXIS_KEEP_WIDTH = 64,
   parameter int AXIS_USER_WIDTH = 16
) (
   input  logic                       axis_aclk,
   input  logic                       axis_rst,

   input  logic                       s_axis_roce_tvalid,
   input  logic [AXIS_DATA_WIDTH-1:0] s_axis_roce_tdata,
   input  logic [AXIS_KEEP_WIDTH-1:0] s_axis_roce_tkeep,
   input  logic [AXIS_USER_WIDTH-1:0] s_axis_roce_tuser_size,
   input  logic                       s_axis_roce_tlast,
   output logic                       s_axis_roce_tready,

   input  logic                       s_axis_non_roce_tvalid,
   input  logic [AXIS_DATA_WIDTH-1:0] s_axis_non_roce_tdata,
   input  logic [AXIS_KEEP_WIDTH-1:0] s_axis_non_roce_tkeep,
   input  logic [AXIS_USER_WIDTH-1:0] s_axis_non_roce_tuser_size,
   input  logic                       s_axis_non_roce_tlast,
   output logic                       s_axis_non_roce_tready,

   output logic                       m_axis_tvalid,
   output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata,
   output logic [AXIS_KEEP_WIDTH-1:0] m_axis_tkeep,
   output logic [AXIS_USER_WIDTH-1:0] m_axis_tuser_size,
   output logic                       m_axis_tlast,
   input  logic                       m_axis_tready,

   output logic [31:0]                pkt_cnt_roce,
   output logic [31:0]                pkt_cnt_non_roce,
   output logic [1:0]                 grant
);

   // State encoding doubles as the grant code (00 idle, 01 RoCE, 10 non-RoCE).
   typedef enum logic [1:0] {
      IDLE          = 2'b00,
      LOCK_ROCE     = 2'b01,
      LOCK_NON_ROCE = 2'b10
   } state_t;

   state_t state;
   state_t state_next;

   logic last_winner_non;   // 1: non-RoCE won the most recent handshake
   logic accept;
   logic sel_roce;
   logic sel_non_roce;
   logic hs_roce;
   logic hs_non_roce;
   logic load;

   assign accept      = !m_axis_tvalid || m_axis_tready;
   assign hs_roce     = s_axis_roce_tvalid && s_axis_roce_tready;
   assign hs_non_roce = s_axis_non_roce_tvalid && s_axis_non_roce_tready;
   assign load        = hs_roce || hs_non_roce;
   assign grant       = state;

   // State register; reset drops any partial packet and returns to IDLE.
   always_ff @(posedge axis_aclk) begin
      if (axis_rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state: lock on a non-last beat taken in IDLE, unlock on the tlast beat.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (hs_roce && !s_axis_roce_tlast) begin
               state_next = LOCK_ROCE;
            end else if (hs_non_roce && !s_axis_non_roce_tlast) begin
               state_next = LOCK_NON_ROCE;
            end
         end
         LOCK_ROCE: begin
            if (hs_roce && s_axis_roce_tlast) begin
               state_next = IDLE;
            end
         end
         LOCK_NON_ROCE: begin
            if (hs_non_roce && s_axis_non_roce_tlast) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Source selection and ready generation; readies are held low during reset.
   always_comb begin
      sel_roce     = 1'b0;
      sel_non_roce = 1'b0;
      case (state)
         IDLE: begin
            if (s_axis_roce_tvalid && s_axis_non_roce_tvalid) begin
               if (last_winner_non) begin
                  sel_roce = 1'b1;
               end else begin
                  sel_non_roce = 1'b1;
               end
            end else if (s_axis_roce_tvalid) begin
               sel_roce = 1'b1;
            end else if (s_axis_non_roce_tvalid) begin
               sel_non_roce = 1'b1;
            end
         end
         LOCK_ROCE:     sel_roce     = 1'b1;
         LOCK_NON_ROCE: sel_non_roce = 1'b1;
         default: begin
            sel_roce     = 1'b0;
            sel_non_roce = 1'b0;
         end
      endcase
      s_axis_roce_tready     = sel_roce && accept && !axis_rst;
      s_axis_non_roce_tready = sel_non_roce && accept && !axis_rst;
   end

   // Round-robin memory: remembers which source was served last.
   always_ff @(posedge axis_aclk) begin
      if (axis_rst) begin
         last_winner_non <= 1'b1;
      end else if (hs_roce) begin
         last_winner_non <= 1'b0;
      end else if (hs_non_roce) begin
         last_winner_non <= 1'b1;
      end
   end

   // Output register: load the accepted beat, drop valid once it is consumed.
   always_ff @(posedge axis_aclk) begin
      if (axis_rst) begin
         m_axis_tvalid     <= 1'b0;
         m_axis_tdata      <= '0;
         m_axis_tkeep      <= '0;
         m_axis_tuser_size <= '0;
         m_axis_tlast      <= 1'b0;
      end else if (load) begin
         m_axis_tvalid     <= 1'b1;
         m_axis_tdata      <= hs_roce ? s_axis_roce_tdata      : s_axis_non_roce_tdata;
         m_axis_tkeep      <= hs_roce ? s_axis_roce_tkeep      : s_axis_non_roce_tkeep;
         m_axis_tuser_size <= hs_roce ? s_axis_roce_tuser_size : s_axis_non_roce_tuser_size;
         m_axis_tlast      <= hs_roce ? s_axis_roce_tlast      : s_axis_non_roce_tlast;
      end else if (m_axis_tready) begin
         m_axis_tvalid     <= 1'b0;
      end
   end

   // Debug packet counters, bumped on each input-side tlast handshake; they wrap.
   always_ff @(posedge axis_aclk) begin
      if (axis_rst) begin
         pkt_cnt_roce     <= 32'd0;
         pkt_cnt_non_roce <= 32'd0;
      end else begin
         if (hs_roce && s_axis_roce_tlast) begin
            pkt_cnt_roce <= pkt_cnt_roce + 32'd1;
         end
         if (hs_non_roce && s_axis_non_roce_tlast) begin
            pkt_cnt_non_roce <= pkt_cnt_non_roce + 32'd1;
         end
      end
   end

endmodule
